// File: rtl/s1423_n75_pattern_driver.sv
// s1423_n75_pattern_driver: serial-in / response-out harness around the
// combinational cone s1423_n75. It loads N_IN pattern bits plus an expected
// bit, applies the pattern in parallel, waits SETTLE cycles, captures n75,
// returns it with a mismatch flag and keeps saturating pattern/error counters.
// Optional feature macro: S1423_DRV_FIRST_ERR_EN (sticky first-mismatch index).
module s1423_n75_pattern_driver #(
  parameter int N_IN   = 26,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_data,
  output logic [N_IN-1:0]  pat,
  input  logic             cone_out,
  output logic             r_valid,
  input  logic             r_ready,
  output logic             r_data,
  output logic             r_mismatch,
  output logic [CNT_W-1:0] pat_cnt,
  output logic [CNT_W-1:0] err_cnt
`ifdef S1423_DRV_FIRST_ERR_EN
  ,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             first_err_vld
`endif
);

  localparam int BI_W = $clog2(N_IN + 1);

  // SETTLE must leave at least one stable cycle and fit the 4-bit counter
  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("s1423_n75_pattern_driver: SETTLE must be in 1..15");
  end

  typedef enum logic [1:0] {LOAD, SETTLE_S, CAPTURE, RESP} state_t;

  state_t            state_q, state_d;
  logic [BI_W-1:0]   beat_q, beat_d;
  logic [3:0]        set_q, set_d;
  logic [N_IN-1:0]   shadow_q, shadow_d;
  logic [N_IN-1:0]   pat_q, pat_d;
  logic              exp_q, exp_d;
  logic              s_ready_q, s_ready_d;
  logic              r_valid_q, r_valid_d;
  logic              r_data_q, r_data_d;
  logic              r_mm_q, r_mm_d;
  logic [CNT_W-1:0]  pat_cnt_q, pat_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
`ifdef S1423_DRV_FIRST_ERR_EN
  logic [CNT_W-1:0]  fe_idx_q, fe_idx_d;
  logic              fe_vld_q, fe_vld_d;
`endif

  // Next-state and datapath updates; every target defaults to its hold value
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    set_d     = set_q;
    shadow_d  = shadow_q;
    pat_d     = pat_q;
    exp_d     = exp_q;
    r_valid_d = r_valid_q;
    r_data_d  = r_data_q;
    r_mm_d    = r_mm_q;
    pat_cnt_d = pat_cnt_q;
    err_cnt_d = err_cnt_q;
`ifdef S1423_DRV_FIRST_ERR_EN
    fe_idx_d  = fe_idx_q;
    fe_vld_d  = fe_vld_q;
`endif
    case (state_q)
      LOAD: begin
        if (s_valid && s_ready_q) begin
          if (beat_q == BI_W'(N_IN)) begin
            // Expected bit: the whole pattern reaches the cone on this edge
            exp_d   = s_data;
            pat_d   = shadow_q;
            set_d   = '0;
            state_d = SETTLE_S;
          end else begin
            shadow_d[beat_q] = s_data;
            beat_d           = beat_q + BI_W'(1);
          end
        end
      end
      SETTLE_S: begin
        set_d = set_q + 4'd1;
        if (set_q == 4'(SETTLE - 1)) state_d = CAPTURE;
      end
      CAPTURE: begin
        r_data_d  = cone_out;
        r_mm_d    = cone_out ^ exp_q;
        r_valid_d = 1'b1;
        state_d   = RESP;
      end
      RESP: begin
        if (r_ready) begin
          r_valid_d = 1'b0;
          beat_d    = '0;
          state_d   = LOAD;
          if (!(&pat_cnt_q)) pat_cnt_d = pat_cnt_q + CNT_W'(1);
          if (r_mm_q && !(&err_cnt_q)) err_cnt_d = err_cnt_q + CNT_W'(1);
`ifdef S1423_DRV_FIRST_ERR_EN
          if (r_mm_q && !fe_vld_q) begin
            fe_idx_d = pat_cnt_q;
            fe_vld_d = 1'b1;
          end
`endif
        end
      end
      default: state_d = LOAD;
    endcase
    // Registered so s_ready is low during reset and rises the cycle after
    // a response handshake
    s_ready_d = (state_d == LOAD);
  end

  // State register with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LOAD;
      beat_q    <= '0;
      set_q     <= '0;
      shadow_q  <= '0;
      pat_q     <= '0;
      exp_q     <= 1'b0;
      s_ready_q <= 1'b0;
      r_valid_q <= 1'b0;
      r_data_q  <= 1'b0;
      r_mm_q    <= 1'b0;
      pat_cnt_q <= '0;
      err_cnt_q <= '0;
`ifdef S1423_DRV_FIRST_ERR_EN
      fe_idx_q  <= '0;
      fe_vld_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      set_q     <= set_d;
      shadow_q  <= shadow_d;
      pat_q     <= pat_d;
      exp_q     <= exp_d;
      s_ready_q <= s_ready_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      r_mm_q    <= r_mm_d;
      pat_cnt_q <= pat_cnt_d;
      err_cnt_q <= err_cnt_d;
`ifdef S1423_DRV_FIRST_ERR_EN
      fe_idx_q  <= fe_idx_d;
      fe_vld_q  <= fe_vld_d;
`endif
    end
  end

  assign s_ready    = s_ready_q;
  assign pat        = pat_q;
  assign r_valid    = r_valid_q;
  assign r_data     = r_data_q;
  assign r_mismatch = r_mm_q;
  assign pat_cnt    = pat_cnt_q;
  assign err_cnt    = err_cnt_q;
`ifdef S1423_DRV_FIRST_ERR_EN
  assign first_err_idx = fe_idx_q;
  assign first_err_vld = fe_vld_q;
`endif

endmodule
